// File: rtl/prefix_adder_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Kogge-Stone adder.
package prefix_adder_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    // Ceiling log2; 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r++;
        end
        return r;
    endfunction

    // Register stages needed for the prefix tree; at least one so the result is always registered.
    function automatic int num_stages(input int width, input int stage_levels);
        int lv;
        int ns;
        lv = clog2(width);
        ns = (lv + stage_levels - 1) / stage_levels;
        return (ns < 1) ? 1 : ns;
    endfunction

endpackage

// File: rtl/prefix_black_cell.sv
// Radix-2 prefix combine cell; used as a gray cell by leaving p unconnected downstream.
module prefix_black_cell
    import prefix_adder_pkg::*;
(
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g,
    output logic p
);

    assign g = g_hi | (p_hi & g_lo);
    assign p = p_hi & p_lo;

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Kogge-Stone adder with a register stage every STAGE_LEVELS prefix levels and valid/ready flow control.
// Define ADDER_SUB_EN to add the 'sub' port (A-B via inverted B and forced carry-in).
module pipelined_prefix_adder
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int STAGE_LEVELS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int LEVELS = clog2(WIDTH);
    localparam int NS     = num_stages(WIDTH, STAGE_LEVELS);

    logic [WIDTH-1:0] w_b;
    logic             w_cin;

`ifdef ADDER_SUB_EN
    assign w_b   = sub ? ~b : b;
    assign w_cin = sub | cin;
`else
    assign w_b   = b;
    assign w_cin = cin;
`endif

    pg_t  [WIDTH-1:0] w_bit;
    logic [WIDTH-1:0] w_g0;
    logic [WIDTH-1:0] w_pv;

    // Carry-in is folded into bit 0 so every group G below reaches down to position -1.
    always_comb begin
        w_bit = '0;
        w_g0  = '0;
        w_pv  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_bit[i].g = a[i] & w_b[i];
            w_bit[i].p = a[i] ^ w_b[i];
            w_g0[i]    = w_bit[i].g;
            w_pv[i]    = w_bit[i].p;
        end
        w_g0[0] = w_bit[0].g | (w_bit[0].p & w_cin);
    end

    logic [WIDTH-1:0] r_g  [NS];
    logic [WIDTH-1:0] r_p  [NS];
    logic [WIDTH-1:0] r_pv [NS];
    logic [NS-1:0]    r_cin;
    logic [NS-1:0]    r_v;
    logic [WIDTH-1:0] w_sg [NS];
    logic [WIDTH-1:0] w_sp [NS];
    logic [NS-1:0]    w_adv;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int D = 1 << k;
        logic [WIDTH-1:0] w_gi, w_pi, w_go, w_po;

        if (k == 0) begin : g_src_in
            assign w_gi = w_g0;
            assign w_pi = w_pv;
        end else if (k % STAGE_LEVELS == 0) begin : g_src_reg
            assign w_gi = r_g[k/STAGE_LEVELS-1];
            assign w_pi = r_p[k/STAGE_LEVELS-1];
        end else begin : g_src_comb
            assign w_gi = g_lvl[k-1].w_go;
            assign w_pi = g_lvl[k-1].w_po;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= D) begin : g_cell
                prefix_black_cell u_cell (
                    .g_hi (w_gi[i]),
                    .p_hi (w_pi[i]),
                    .g_lo (w_gi[i-D]),
                    .p_lo (w_pi[i-D]),
                    .g    (w_go[i]),
                    .p    (w_po[i])
                );
            end else begin : g_pass
                assign w_go[i] = w_gi[i];
                assign w_po[i] = w_pi[i];
            end
        end
    end

    for (genvar s = 0; s < NS; s++) begin : g_stg
        localparam int E = (LEVELS < (s + 1) * STAGE_LEVELS) ? LEVELS : (s + 1) * STAGE_LEVELS;
        if (E == 0) begin : g_no_tree
            assign w_sg[s] = w_g0;
            assign w_sp[s] = w_pv;
        end else begin : g_tree
            assign w_sg[s] = g_lvl[E-1].w_go;
            assign w_sp[s] = g_lvl[E-1].w_po;
        end
    end

    // Handshake: a beat transfers on valid & ready at the rising edge; a stage may load when it is
    // empty or its successor takes its content this cycle, so in_ready reflects out_ready combinationally.
    always_comb begin
        w_adv         = '0;
        w_adv[NS-1]   = !r_v[NS-1] | out_ready;
        for (int s = NS - 2; s >= 0; s--) begin
            w_adv[s] = !r_v[s] | w_adv[s+1];
        end
    end

    assign in_ready = w_adv[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v   <= '0;
            r_cin <= '0;
            for (int s = 0; s < NS; s++) begin
                r_g[s]  <= '0;
                r_p[s]  <= '0;
                r_pv[s] <= '0;
            end
        end else begin
            if (w_adv[0]) begin
                r_v[0] <= in_valid;
                if (in_valid) begin
                    r_g[0]   <= w_sg[0];
                    r_p[0]   <= w_sp[0];
                    r_pv[0]  <= w_pv;
                    r_cin[0] <= w_cin;
                end
            end
            for (int s = 1; s < NS; s++) begin
                if (w_adv[s]) begin
                    r_v[s] <= r_v[s-1];
                    if (r_v[s-1]) begin
                        r_g[s]   <= w_sg[s];
                        r_p[s]   <= w_sp[s];
                        r_pv[s]  <= r_pv[s-1];
                        r_cin[s] <= r_cin[s-1];
                    end
                end
            end
        end
    end

    assign out_valid = r_v[NS-1];
    assign cout      = r_g[NS-1][WIDTH-1];

    if (WIDTH == 1) begin : g_w1
        assign sum = r_pv[NS-1] ^ r_cin[NS-1];
        assign ovf = r_cin[NS-1] ^ cout;
    end else begin : g_wn
        assign sum = r_pv[NS-1] ^ {r_g[NS-1][WIDTH-2:0], r_cin[NS-1]};
        assign ovf = r_g[NS-1][WIDTH-2] ^ cout;
    end

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench for pipelined_prefix_adder (WIDTH=16, STAGE_LEVELS=2); sub vectors only with ADDER_SUB_EN.
module tb_pipelined_prefix_adder;

    localparam int W = 16;
    localparam int L = 2;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub_r;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    logic [W+1:0] exp_q[$];
    int           acc_q[$];
    int           out_cyc_q[$];
    vec_t         vecs[$];

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int last_lat = -1;
    bit rand_bp  = 0;

    pipelined_prefix_adder #(.WIDTH(W), .STAGE_LEVELS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef ADDER_SUB_EN
        .sub       (sub_r),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycles=%0d required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    // Random backpressure, applied after the driver's update point.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [W+1:0] model(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                           input logic c_i, input logic s_i);
        int          ua, ub, sa, sb, full, ss;
        logic [31:0] fv;
        logic        co, ov;
        ua = a_i;
        ub = b_i;
        sa = $signed(a_i);
        sb = $signed(b_i);
        if (s_i) begin
            full = ua + (65535 - ub) + 1;
            ss   = sa - sb;
        end else begin
            full = ua + ub + int'(c_i);
            ss   = sa + sb + int'(c_i);
        end
        fv = full;
        co = (full > 65535);
        ov = (ss > 32767) || (ss < -32768);
        return {ov, co, fv[W-1:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic c_i,
                        input logic s_i, input logic [W+1:0] exp_i);
        bit ok;
        ok       = 0;
        a        = a_i;
        b        = b_i;
        cin      = c_i;
        sub_r    = s_i;
        in_valid = 1'b1;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(exp_i);
                acc_q.push_back(cyc);
                ok = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
        end
    endtask

    task automatic send_rand();
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        ra = W'($urandom_range(0, 65535));
        rb = W'($urandom_range(0, 65535));
        rc = 1'($urandom_range(0, 1));
`ifdef ADDER_SUB_EN
        rs = 1'($urandom_range(0, 1));
`else
        rs = 1'b0;
`endif
        send(ra, rb, rc, rs, model(ra, rb, rc, rs));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d required=0", exp_q.size());
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b", name, act, req);
        end
    endtask

    task automatic add_vec(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                           input logic vs, input logic [W-1:0] vsum, input logic vco, input logic vov);
        vec_t v;
        v.a = va; v.b = vb; v.cin = vc; v.sub = vs;
        v.sum = vsum; v.cout = vco; v.ovf = vov;
        vecs.push_back(v);
    endtask

    // ---------------- scoreboard / monitor ----------------
    initial begin
        logic [W+1:0] e;
        int           ac;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                checks++;
                out_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out sum=%h cout=%0b ovf=%0b required=none", sum, cout, ovf);
                end else begin
                    e  = exp_q.pop_front();
                    ac = acc_q.pop_front();
                    last_lat = cyc - ac;
                    if ({ovf, cout, sum} !== e) begin
                        errors++;
                        $display("FAIL result sum=%h cout=%0b ovf=%0b required sum=%h cout=%0b ovf=%0b",
                                 sum, cout, ovf, e[W-1:0], e[W], e[W+1]);
                    end
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [W-1:0] ha, hb;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub_r     = 1'b0;
        out_ready = 1'b1;

        add_vec(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        add_vec(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        add_vec(16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0);
        add_vec(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        add_vec(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        add_vec(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        add_vec(16'h5555, 16'hAAAA, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        add_vec(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
`ifdef ADDER_SUB_EN
        add_vec(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        add_vec(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_bit("reset_out_valid", out_valid, 1'b0);
        checks++;
        if ({ovf, cout, sum} !== '0) begin
            errors++;
            $display("FAIL reset_data sum=%h cout=%0b ovf=%0b required=0", sum, cout, ovf);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_bit("in_ready_after_reset", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Directed vectors, each through an idle pipe so the latency is exact.
        for (int i = 0; i < vecs.size(); i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                 {vecs[i].ovf, vecs[i].cout, vecs[i].sum});
            wait_drain();
            checks++;
            if (last_lat != L) begin
                errors++;
                $display("FAIL latency vec=%0d actual=%0d required=%0d", i, last_lat, L);
            end
        end

        // Eight back-to-back operations must emerge on consecutive cycles.
        out_cyc_q.delete();
        for (int i = 0; i < 8; i++) send_rand();
        wait_drain();
        checks++;
        if (out_cyc_q.size() != 8) begin
            errors++;
            $display("FAIL b2b_count actual=%0d required=8", out_cyc_q.size());
        end else begin
            for (int i = 1; i < 8; i++) begin
                checks++;
                if (out_cyc_q[i] != out_cyc_q[0] + i) begin
                    errors++;
                    $display("FAIL b2b_gap idx=%0d actual=%0d required=%0d", i, out_cyc_q[i], out_cyc_q[0] + i);
                end
            end
        end

        // Stall: two entries fill the pipe, the third waits while outputs hold.
        out_ready = 1'b0;
        send_rand();
        send_rand();
        ha       = W'($urandom_range(0, 65535));
        hb       = W'($urandom_range(0, 65535));
        a        = ha;
        b        = hb;
        cin      = 1'b1;
        sub_r    = 1'b0;
        in_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check_bit("stall_in_ready", in_ready, 1'b0);
            check_bit("stall_out_valid", out_valid, 1'b1);
            checks++;
            if (exp_q.size() == 0 || {ovf, cout, sum} !== exp_q[0]) begin
                errors++;
                $display("FAIL stall_hold sum=%h cout=%0b ovf=%0b required_head=%h", sum, cout, ovf,
                         (exp_q.size() != 0) ? exp_q[0] : '0);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(ha, hb, 1'b1, 1'b0, model(ha, hb, 1'b1, 1'b0));
        send_rand();
        wait_drain();

        // Asynchronous reset with two entries in flight.
        out_ready = 1'b0;
        send_rand();
        send_rand();
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("async_rst_out_valid", out_valid, 1'b0);
        checks++;
        if ({ovf, cout, sum} !== '0) begin
            errors++;
            $display("FAIL async_rst_data sum=%h cout=%0b ovf=%0b required=0", sum, cout, ovf);
        end
        exp_q.delete();
        acc_q.delete();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_bit("post_rst_in_ready", in_ready, 1'b1);
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            check_bit("post_rst_no_stale", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;

        // Random traffic with random backpressure and idle gaps.
        rand_bp = 1;
        for (int i = 0; i < 200; i++) begin
            send_rand();
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_bp   = 0;
        out_ready = 1'b1;
        wait_drain();
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
